alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_dispatch.sv | 164 ++++++++++++++++
 tb/tb_alu_dispatch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch block: widths, opcodes, FSM states
// and the packed command layout stored in the command FIFO.
package alu_pkg;

  localparam int DATA_W = 12;
  localparam int OP_W   = 3;
  localparam int CMD_W  = 2 * DATA_W + OP_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_MUL    = 3'b010,
    OP_MAC    = 3'b011,
    OP_XNOR   = 3'b100,
    OP_RELU   = 3'b101,
    OP_MEAN   = 3'b110,
    OP_ABSMAX = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   inst;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_dispatch: DEPTH entries of one packed command each,
// extra pointer MSB distinguishes full from empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_data,
  input  logic             i_pop,
  output logic [CMD_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic             doPush;
  logic             doPop;

  assign o_empty = (wrPtr_q == rdPtr_q);
  assign o_full  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign doPop   = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign doPush  = i_push && (!o_full || doPop);
  assign o_data  = mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (doPop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/alu_dispatch.sv
// Buffers ALU commands, issues one at a time to an external ALU, waits for
// the reply (or a timeout) and holds the result until downstream takes it.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DATA_W-1:0] i_cmd_a,
  input  logic [DATA_W-1:0] i_cmd_b,
  input  logic [OP_W-1:0]   i_cmd_inst,
  output logic              o_alu_valid,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [OP_W-1:0]   o_alu_inst,
  input  logic              i_alu_valid,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_alu_overflow,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_data,
  output logic              o_res_overflow,
  output logic [OP_W-1:0]   o_res_inst,
  output logic              o_res_timeout
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] aluA_q, aluA_d;
  logic [DATA_W-1:0] aluB_q, aluB_d;
  logic [OP_W-1:0]   aluInst_q, aluInst_d;
  logic [DATA_W-1:0] resData_q, resData_d;
  logic              resOvf_q, resOvf_d;
  logic [OP_W-1:0]   resInst_q, resInst_d;
  logic              resTimeout_q, resTimeout_d;

  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CMD_W-1:0]  fifoData;
  cmd_t              head;

  assign head = cmd_t'(fifoData);

  // The slot freed by a same-cycle pop can be refilled, so ready covers it.
  assign o_cmd_ready = !fifoFull || fifoPop;
  assign fifoPush    = i_cmd_valid && o_cmd_ready;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifoPush),
    .i_data  ({i_cmd_a, i_cmd_b, i_cmd_inst}),
    .i_pop   (fifoPop),
    .o_data  (fifoData),
    .o_full  (fifoFull),
    .o_empty (fifoEmpty)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    aluA_d       = aluA_q;
    aluB_d       = aluB_q;
    aluInst_d    = aluInst_q;
    resData_d    = resData_q;
    resOvf_d     = resOvf_q;
    resInst_d    = resInst_q;
    resTimeout_d = resTimeout_q;
    fifoPop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          aluA_d    = head.a;
          aluB_d    = head.b;
          aluInst_d = head.inst;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_alu_valid) begin
          resData_d    = i_alu_data;
          resOvf_d     = i_alu_overflow;
          resInst_d    = aluInst_q;
          resTimeout_d = 1'b0;
          cnt_d        = '0;
          state_d      = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          resData_d    = '0;
          resOvf_d     = 1'b0;
          resInst_d    = aluInst_q;
          resTimeout_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (i_res_ready) begin
          if (!fifoEmpty) begin
            fifoPop   = 1'b1;
            aluA_d    = head.a;
            aluB_d    = head.b;
            aluInst_d = head.inst;
            state_d   = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      aluA_q       <= '0;
      aluB_q       <= '0;
      aluInst_q    <= '0;
      resData_q    <= '0;
      resOvf_q     <= 1'b0;
      resInst_q    <= '0;
      resTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      aluA_q       <= aluA_d;
      aluB_q       <= aluB_d;
      aluInst_q    <= aluInst_d;
      resData_q    <= resData_d;
      resOvf_q     <= resOvf_d;
      resInst_q    <= resInst_d;
      resTimeout_q <= resTimeout_d;
    end
  end

  assign o_alu_valid    = (state_q == ST_ISSUE);
  assign o_alu_a        = aluA_q;
  assign o_alu_b        = aluB_q;
  assign o_alu_inst     = aluInst_q;
  assign o_res_valid    = (state_q == ST_HOLD);
  assign o_res_data     = resData_q;
  assign o_res_overflow = resOvf_q;
  assign o_res_inst     = resInst_q;
  assign o_res_timeout  = resTimeout_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared each cycle to a transaction model.
module tb_alu_dispatch;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [11:0] i_cmd_a = '0;
  logic [11:0] i_cmd_b = '0;
  logic [2:0]  i_cmd_inst = '0;
  logic        o_alu_valid;
  logic [11:0] o_alu_a;
  logic [11:0] o_alu_b;
  logic [2:0]  o_alu_inst;
  logic        i_alu_valid = 1'b0;
  logic [11:0] i_alu_data = '0;
  logic        i_alu_overflow = 1'b0;
  logic        o_res_valid;
  logic        i_res_ready = 1'b0;
  logic [11:0] o_res_data;
  logic        o_res_overflow;
  logic [2:0]  o_res_inst;
  logic        o_res_timeout;

  alu_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_inst(i_cmd_inst),
    .o_alu_valid(o_alu_valid), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_inst(o_alu_inst),
    .i_alu_valid(i_alu_valid), .i_alu_data(i_alu_data), .i_alu_overflow(i_alu_overflow),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_data(o_res_data), .o_res_overflow(o_res_overflow),
    .o_res_inst(o_res_inst), .o_res_timeout(o_res_timeout)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a queue for buffered commands, one in-flight op tagged
  // with the cycle it is presented to the ALU, and one held result.
  bit [26:0] mq[$];
  bit        haveOp;
  bit        haveResult;
  int        cyc;
  int        issueCycle;
  bit [11:0] mAluA, mAluB, mResData;
  bit [2:0]  mAluInst, mResInst;
  bit        mResOvf, mResTo;

  function automatic bit modelCanPop();
    return (mq.size() > 0) && ((!haveOp && !haveResult) || (haveResult && i_res_ready));
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mq.delete();
      haveOp = 0; haveResult = 0; cyc = 0; issueCycle = 0;
      mAluA = 0; mAluB = 0; mAluInst = 0;
      mResData = 0; mResInst = 0; mResOvf = 0; mResTo = 0;
    end else begin
      bit pop;
      bit push;
      bit [26:0] headCmd;
      pop  = modelCanPop();
      push = i_cmd_valid && ((mq.size() < DEPTH) || pop);
      if (haveResult && i_res_ready) haveResult = 0;
      if (haveOp && cyc > issueCycle) begin
        if (i_alu_valid) begin
          mResData = i_alu_data; mResOvf = i_alu_overflow; mResTo = 0; mResInst = mAluInst;
          haveOp = 0; haveResult = 1;
        end else if (cyc - issueCycle == TIMEOUT) begin
          mResData = 0; mResOvf = 0; mResTo = 1; mResInst = mAluInst;
          haveOp = 0; haveResult = 1;
        end
      end
      if (pop) begin
        headCmd = mq.pop_front();
        {mAluA, mAluB, mAluInst} = headCmd;
        haveOp = 1;
        issueCycle = cyc + 1;
      end
      if (push) mq.push_back({i_cmd_a, i_cmd_b, i_cmd_inst});
      cyc++;
    end
  end

  always @(negedge i_clk) begin
    bit issuing;
    issuing = haveOp && (cyc == issueCycle);
    checkOutput("cmp_cmd_ready", 32'(o_cmd_ready), 32'((mq.size() < DEPTH) || modelCanPop()));
    checkOutput("cmp_alu_valid", 32'(o_alu_valid), 32'(issuing));
    checkOutput("cmp_alu_a", 32'(o_alu_a), 32'(mAluA));
    checkOutput("cmp_alu_b", 32'(o_alu_b), 32'(mAluB));
    checkOutput("cmp_alu_inst", 32'(o_alu_inst), 32'(mAluInst));
    checkOutput("cmp_res_valid", 32'(o_res_valid), 32'(haveResult));
    checkOutput("cmp_res_data", 32'(o_res_data), 32'(mResData));
    checkOutput("cmp_res_overflow", 32'(o_res_overflow), 32'(mResOvf));
    checkOutput("cmp_res_inst", 32'(o_res_inst), 32'(mResInst));
    checkOutput("cmp_res_timeout", 32'(o_res_timeout), 32'(mResTo));
  end

  // ALU responder modes: 0 silent, 1 echo a+rspAdd one cycle after issue,
  // 2 random pulses, 3 valid every cycle.
  int          aluMode = 1;
  logic [11:0] rspAdd = '0;
  logic        rspOvf = 1'b0;
  logic        lastIssue = 1'b0;
  logic [11:0] lastA = '0;

  task automatic stepCycle();
    @(negedge i_clk);
    lastIssue = o_alu_valid;
    lastA     = o_alu_a;
    @(posedge i_clk);
    #1;
    case (aluMode)
      0: i_alu_valid = 1'b0;
      1: begin
        i_alu_valid    = lastIssue;
        i_alu_data     = lastA + rspAdd;
        i_alu_overflow = rspOvf;
      end
      2: begin
        i_alu_valid    = ($urandom_range(0, 99) < 30);
        i_alu_data     = 12'($urandom);
        i_alu_overflow = 1'($urandom);
      end
      default: begin
        i_alu_valid    = 1'b1;
        i_alu_data     = 12'($urandom);
        i_alu_overflow = 1'b1;
      end
    endcase
  endtask

  task automatic applyStimulus(input bit v, input logic [11:0] a, input logic [11:0] b,
                               input logic [2:0] inst, input bit rr);
    i_cmd_valid = v;
    i_cmd_a     = a;
    i_cmd_b     = b;
    i_cmd_inst  = inst;
    i_res_ready = rr;
  endtask

  logic [11:0] got[$];

  initial begin
    repeat (2) stepCycle();
    checkOutput("reset_cmd_ready", 32'(o_cmd_ready), 32'd1);
    checkOutput("reset_alu_valid", 32'(o_alu_valid), 32'd0);
    checkOutput("reset_res_valid", 32'(o_res_valid), 32'd0);
    i_rst_n = 1'b1;
    stepCycle();

    // Single ADD, 1-cycle ALU reply of 5+3
    aluMode = 1; rspAdd = 12'd3; rspOvf = 1'b0;
    applyStimulus(1, 12'h005, 12'h003, OP_ADD, 0);
    stepCycle();
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 0);
    checkOutput("t1_n1_alu_valid", 32'(o_alu_valid), 32'd0);
    stepCycle();
    checkOutput("t1_n2_alu_valid", 32'(o_alu_valid), 32'd1);
    checkOutput("t1_n2_alu_a", 32'(o_alu_a), 32'h005);
    checkOutput("t1_n2_alu_b", 32'(o_alu_b), 32'h003);
    stepCycle();
    checkOutput("t1_n3_alu_valid", 32'(o_alu_valid), 32'd0);
    checkOutput("t1_n3_res_valid", 32'(o_res_valid), 32'd0);
    stepCycle();
    checkOutput("t1_n4_res_valid", 32'(o_res_valid), 32'd1);
    checkOutput("t1_n4_res_data", 32'(o_res_data), 32'h008);
    checkOutput("t1_n4_res_inst", 32'(o_res_inst), 32'd0);
    checkOutput("t1_n4_res_ovf", 32'(o_res_overflow), 32'd0);
    checkOutput("t1_n4_res_timeout", 32'(o_res_timeout), 32'd0);
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 1);
    stepCycle();

    // Five pushes while stalled, then push+pop on a full FIFO
    rspAdd = 12'd0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 12'(100 + k), 12'(k), 3'(k), 0);
      stepCycle();
    end
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 0);
    checkOutput("t2_ready_after_5th", 32'(o_cmd_ready), 32'd0);
    applyStimulus(1, 12'd105, 12'd5, 3'd5, 1);
    #1;
    checkOutput("t3_ready_full_pop", 32'(o_cmd_ready), 32'd1);
    if (o_res_valid === 1'b1) got.push_back(o_res_data);
    stepCycle();
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 1);
    checkOutput("t3_still_full", 32'(o_cmd_ready), 32'd0);
    for (int i = 0; i < 40 && got.size() < 6; i++) begin
      if (o_res_valid === 1'b1) got.push_back(o_res_data);
      stepCycle();
    end
    checkOutput("t2_result_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size(); i++)
      checkOutput("t2_result_order", 32'(got[i]), 32'(100 + i));

    // Silent ALU -> timeout marker, then a normal command
    aluMode = 0;
    applyStimulus(1, 12'h7ff, 12'h001, OP_MAC, 0);
    stepCycle();
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 0);
    for (int i = 0; i < 10 && o_alu_valid !== 1'b1; i++) stepCycle();
    checkOutput("t4_issue_seen", 32'(o_alu_valid), 32'd1);
    repeat (TIMEOUT) begin
      stepCycle();
      checkOutput("t4_wait_no_result", 32'(o_res_valid), 32'd0);
    end
    stepCycle();
    checkOutput("t4_to_res_valid", 32'(o_res_valid), 32'd1);
    checkOutput("t4_to_res_data", 32'(o_res_data), 32'd0);
    checkOutput("t4_to_timeout", 32'(o_res_timeout), 32'd1);
    checkOutput("t4_to_inst", 32'(o_res_inst), 32'(OP_MAC));
    aluMode = 1; rspAdd = 12'd1;
    applyStimulus(1, 12'h010, 12'h020, OP_SUB, 1);
    stepCycle();
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 0);
    for (int i = 0; i < 10 && o_res_valid !== 1'b1; i++) stepCycle();
    checkOutput("t4_next_res_valid", 32'(o_res_valid), 32'd1);
    checkOutput("t4_next_res_data", 32'(o_res_data), 32'h011);
    checkOutput("t4_next_timeout", 32'(o_res_timeout), 32'd0);
    checkOutput("t4_next_inst", 32'(o_res_inst), 32'(OP_SUB));
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 1);
    stepCycle();

    // Reset during WAIT with two commands queued
    aluMode = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 12'(200 + k), 12'(k), OP_XNOR, 0);
      stepCycle();
    end
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 0);
    i_rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_alu_valid", 32'(o_alu_valid), 32'd0);
    checkOutput("t5_rst_alu_a", 32'(o_alu_a), 32'd0);
    checkOutput("t5_rst_res_valid", 32'(o_res_valid), 32'd0);
    checkOutput("t5_rst_res_data", 32'(o_res_data), 32'd0);
    checkOutput("t5_rst_res_timeout", 32'(o_res_timeout), 32'd0);
    checkOutput("t5_rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    repeat (2) stepCycle();
    i_rst_n = 1'b1;
    aluMode = 3;
    repeat (6) begin
      stepCycle();
      checkOutput("t5_no_issue", 32'(o_alu_valid), 32'd0);
      checkOutput("t5_no_result", 32'(o_res_valid), 32'd0);
    end

    // MUL with overflow held through a downstream stall
    aluMode = 1; rspAdd = 12'd0; rspOvf = 1'b1;
    applyStimulus(1, 12'h123, 12'h004, OP_MUL, 0);
    stepCycle();
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 0);
    for (int i = 0; i < 10 && o_res_valid !== 1'b1; i++) stepCycle();
    checkOutput("t6_res_valid", 32'(o_res_valid), 32'd1);
    repeat (3) begin
      stepCycle();
      checkOutput("t6_stall_valid", 32'(o_res_valid), 32'd1);
      checkOutput("t6_stall_ovf", 32'(o_res_overflow), 32'd1);
      checkOutput("t6_stall_data", 32'(o_res_data), 32'h123);
      checkOutput("t6_stall_inst", 32'(o_res_inst), 32'(OP_MUL));
    end
    rspOvf = 1'b0;
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 1);
    stepCycle();

    // Randomized traffic against the model
    aluMode = 2;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) < 50, 12'($urandom), 12'($urandom),
                    3'($urandom), $urandom_range(0, 99) < 60);
      stepCycle();
    end
    applyStimulus(0, 12'h0, 12'h0, 3'd0, 1);
    repeat (20) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
